// File: rtl/switch_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, counter debounce, and a small
// event FSM that emits single-cycle press, release and long-press pulses.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int LONG_PRESS_LIMIT = 25000000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long_Press
);

  localparam int DB_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int LP_W = $clog2(LONG_PRESS_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2;
  logic [DB_W-1:0]   db_cnt;
  logic [LP_W-1:0]   long_cnt, long_cnt_nxt;
  logic              accept, accept_rise, accept_fall;
  logic              press_nxt, release_nxt, long_nxt;

  // The debounce counter only reaches its terminal value while sync2 disagrees
  // with o_Switch, so acceptance always flips the debounced level.
  assign accept      = (sync2 != o_Switch) && (db_cnt == DB_W'(DEBOUNCE_LIMIT - 1));
  assign accept_rise = accept & sync2;
  assign accept_fall = accept & ~sync2;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, matching real hardware ordering.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      o_Switch <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1 <= i_Switch;
      sync2 <= sync1;
      if (sync2 == o_Switch) begin
        db_cnt <= '0;
      end else if (accept) begin
        o_Switch <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // NOTE: the reset here is synchronous; it is only seen on a rising i_Clk edge.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= IDLE;
      long_cnt     <= '0;
      o_Press      <= 1'b0;
      o_Release    <= 1'b0;
      o_Long_Press <= 1'b0;
    end else begin
      state        <= state_nxt;
      long_cnt     <= long_cnt_nxt;
      o_Press      <= press_nxt;
      o_Release    <= release_nxt;
      o_Long_Press <= long_nxt;
    end
  end

  // NOTE: every output of this block is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    long_cnt_nxt = long_cnt;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept_rise) begin
          press_nxt    = 1'b1;
          long_cnt_nxt = '0;
          state_nxt    = PRESSED;
        end
      end
      PRESSED: begin
        // Release takes priority over a long-press expiry on the same edge.
        if (accept_fall) begin
          release_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (long_cnt == LP_W'(LONG_PRESS_LIMIT - 1)) begin
          long_nxt  = 1'b1;
          state_nxt = LONG;
        end else begin
          long_cnt_nxt = long_cnt + 1'b1;
        end
      end
      LONG: begin
        if (accept_fall) begin
          release_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a cycle-level reference model that
// reasons in terms of sample delay, stable windows and press age.
module tb_switch_debounce;

  localparam int DB = 4;
  localparam int LP = 10;

  logic i_Clk = 1'b0;
  logic i_Reset;
  logic i_Switch;
  logic o_Switch, o_Press, o_Release, o_Long_Press;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int long_pulses = 0;

  switch_debounce #(
    .DEBOUNCE_LIMIT  (DB),
    .LONG_PRESS_LIMIT(LP)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Switch    (i_Switch),
    .o_Switch    (o_Switch),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Long_Press(o_Long_Press)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  // Reference model: input seen two edges late; the level flips once the last
  // DB delayed samples all disagree with it; long press fires LP edges after
  // the press edge unless the level has dropped by then.
  bit m_d1, m_d2, m_level, m_all_diff;
  bit m_win[DB];
  int m_age;
  bit m_long_done, m_press, m_rel, m_long;

  always @(posedge i_Clk) begin
    if (i_Reset) begin
      m_d1 = 0; m_d2 = 0; m_level = 0;
      for (int i = 0; i < DB; i++) m_win[i] = 0;
      m_age = 0; m_long_done = 0;
      m_press = 0; m_rel = 0; m_long = 0;
    end else begin
      for (int i = 0; i < DB - 1; i++) m_win[i] = m_win[i+1];
      m_win[DB-1] = m_d2;
      m_d2 = m_d1;
      m_d1 = i_Switch;
      m_press = 0; m_rel = 0; m_long = 0;
      m_all_diff = 1;
      for (int i = 0; i < DB; i++) if (m_win[i] == m_level) m_all_diff = 0;
      if (m_all_diff) begin
        m_level = !m_level;
        if (m_level) begin
          m_press = 1; m_age = 0; m_long_done = 0;
        end else begin
          m_rel = 1;
        end
      end else if (m_level && !m_long_done) begin
        m_age++;
        if (m_age == LP) begin
          m_long = 1; m_long_done = 1;
        end
      end
    end
  end

  always @(negedge i_Clk) begin
    if (cmp_en) begin
      check("cmp_switch", o_Switch, m_level);
      check("cmp_press", o_Press, m_press);
      check("cmp_release", o_Release, m_rel);
      check("cmp_long", o_Long_Press, m_long);
      if (o_Long_Press === 1'b1) long_pulses++;
    end
  end

  bit glitch[9] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
  int lp_before;

  initial begin
    i_Reset  = 1'b1;
    i_Switch = 1'b0;
    tick(2);
    cmp_en = 1'b1;
    check("rst_switch", o_Switch, 1'b0);
    check("rst_press", o_Press, 1'b0);
    check("rst_release", o_Release, 1'b0);
    check("rst_long", o_Long_Press, 1'b0);
    i_Reset = 1'b0;
    tick(3);

    // Clean press: accepted after edge 6, pulse gone after edge 7.
    i_Switch = 1'b1;
    tick(5);
    check("clean_sw_e5", o_Switch, 1'b0);
    check("clean_press_e5", o_Press, 1'b0);
    tick(1);
    check("clean_sw_e6", o_Switch, 1'b1);
    check("clean_press_e6", o_Press, 1'b1);
    tick(1);
    check("clean_press_e7", o_Press, 1'b0);

    // Short press: release sampled 3 edges after the press edge.
    tick(1);
    i_Switch = 1'b0;
    tick(5);
    check("short_rel_e5", o_Release, 1'b0);
    tick(1);
    check("short_rel_e6", o_Release, 1'b1);
    check("short_sw", o_Switch, 1'b0);
    tick(1);
    check("short_rel_e7", o_Release, 1'b0);
    check_int("short_no_long", long_pulses, 0);
    tick(4);

    // Bouncing press: 1,1,1,0 then steady 1.
    i_Switch = 1'b1; tick(1);
    i_Switch = 1'b1; tick(1);
    i_Switch = 1'b1; tick(1);
    i_Switch = 1'b0; tick(1);
    i_Switch = 1'b1;
    tick(5);
    check("bounce_sw_e5", o_Switch, 1'b0);
    tick(1);
    check("bounce_press_e6", o_Press, 1'b1);
    i_Switch = 1'b0;
    tick(12);

    // Long press: expiry 10 edges after the press edge, then release.
    lp_before = long_pulses;
    i_Switch = 1'b1;
    tick(6);
    check("long_press", o_Press, 1'b1);
    tick(9);
    check("long_e9", o_Long_Press, 1'b0);
    tick(1);
    check("long_e10", o_Long_Press, 1'b1);
    tick(1);
    check("long_e11", o_Long_Press, 1'b0);
    tick(19);
    i_Switch = 1'b0;
    tick(5);
    check("long_rel_e5", o_Release, 1'b0);
    tick(1);
    check("long_rel_e6", o_Release, 1'b1);
    check_int("long_once", long_pulses - lp_before, 1);
    tick(4);

    // Glitches of 1, 2 and 3 cycles during a hold.
    i_Switch = 1'b1;
    tick(6);
    check("glitch_press", o_Press, 1'b1);
    for (int i = 0; i < 9; i++) begin
      i_Switch = glitch[i];
      tick(1);
    end
    tick(1);
    check("glitch_long_e10", o_Long_Press, 1'b1);
    check("glitch_sw", o_Switch, 1'b1);
    tick(5);
    check("glitch_sw_hold", o_Switch, 1'b1);
    i_Switch = 1'b0;
    tick(10);

    // Reset mid-press, then re-detection after the full interval.
    i_Switch = 1'b1;
    tick(9);
    check("rmid_pressed_sw", o_Switch, 1'b1);
    i_Reset = 1'b1;
    tick(1);
    i_Reset = 1'b0;
    check("rmid_sw", o_Switch, 1'b0);
    check("rmid_press", o_Press, 1'b0);
    check("rmid_long", o_Long_Press, 1'b0);
    tick(5);
    check("rmid_press_e5", o_Press, 1'b0);
    tick(1);
    check("rmid_press_e6", o_Press, 1'b1);

    // Release accepted on the expiry edge: release wins.
    tick(4);
    i_Switch = 1'b0;
    tick(6);
    check("simul_rel", o_Release, 1'b1);
    check("simul_long", o_Long_Press, 1'b0);
    tick(15);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
